// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the single-port memory arbiter.
// RAM handshake encoding, arbiter FSM states, grant side and the error fill word.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IACC = 2'd1,
    DACC = 2'd2,
    DONE = 2'd3
  } arb_state_t;

  typedef enum logic {
    GRANT_I = 1'b0,
    GRANT_D = 1'b1
  } grant_t;

  localparam logic [31:0] ERR_WORD = 32'hBAD1BAD1;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of instruction, data and RAM-side signals around the arbiter.
// master: the arbiter itself; slave: the CPU request paths plus the RAM model.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              iREN;
  logic [ADDR_W-1:0] iaddr;
  logic [DATA_W-1:0] iload;
  logic              ihit;
  logic              dREN;
  logic              dWEN;
  logic [ADDR_W-1:0] daddr;
  logic [DATA_W-1:0] dstore;
  logic [DATA_W-1:0] dload;
  logic              dhit;
  logic              ramREN;
  logic              ramWEN;
  logic [ADDR_W-1:0] ramaddr;
  logic [DATA_W-1:0] ramstore;
  logic [DATA_W-1:0] ramload;
  logic [1:0]        ramstate;
  logic              memerr;

  modport master (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iload, ihit, dload, dhit, ramREN, ramWEN, ramaddr, ramstore, memerr
  );

  modport slave (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  iload, ihit, dload, dhit, ramREN, ramWEN, ramaddr, ramstore, memerr
  );
endinterface

// File: rtl/arb_watchdog.sv
// Access-duration counter; expired_o is high while the count equals TIMEOUT.
// Clear has priority over enable.
module arb_watchdog #(
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 200
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign expired_o = (cnt_q == CNT_W'(TIMEOUT));
endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates instruction fetch and data requests onto one RAM port, one access at a time.
// Ties alternate by last grant; a watchdog turns a stuck access into a sticky memerr.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 200,
  parameter int CNT_W   = 8
) (
  input logic           CLK,
  input logic           RST,
  mem_arbiter_if.master bus
);
  arb_state_t        state_q;
  grant_t            last_q;
  logic              wr_q;
  logic              ramren_q, ramwen_q;
  logic [ADDR_W-1:0] ramaddr_q;
  logic [DATA_W-1:0] ramstore_q;
  logic [DATA_W-1:0] iload_q, dload_q;
  logic              ihit_q, dhit_q;
  logic              memerr_q;

  logic              d_req, pick_d, in_acc, wd_expired;
  logic              done_now, err_now;
  ramstate_t         ramst;
  logic [DATA_W-1:0] rd_word;

  assign d_req    = bus.dREN | bus.dWEN;
  // On a tie the D side wins only if I was granted last.
  assign pick_d   = d_req && (!bus.iREN || last_q == GRANT_I);
  assign in_acc   = (state_q == IACC) || (state_q == DACC);
  assign ramst    = ramstate_t'(bus.ramstate);
  assign err_now  = (ramst != ACCESS);
  assign done_now = (ramst == ACCESS) || (ramst == ERROR) || wd_expired;
  assign rd_word  = err_now ? DATA_W'(ERR_WORD) : bus.ramload;

  arb_watchdog #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) u_wd (
    .clk       (CLK),
    .rst       (RST),
    .clr_i     (state_q == DONE),
    .en_i      (in_acc),
    .expired_o (wd_expired)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= IDLE;
      last_q     <= GRANT_I;
      wr_q       <= 1'b0;
      ramren_q   <= 1'b0;
      ramwen_q   <= 1'b0;
      ramaddr_q  <= '0;
      ramstore_q <= '0;
      iload_q    <= '0;
      dload_q    <= '0;
      ihit_q     <= 1'b0;
      dhit_q     <= 1'b0;
      memerr_q   <= 1'b0;
    end else begin
      ihit_q <= 1'b0;
      dhit_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pick_d) begin
            last_q     <= GRANT_D;
            ramaddr_q  <= bus.daddr;
            ramstore_q <= bus.dstore;
            wr_q       <= bus.dWEN;
            ramren_q   <= !bus.dWEN;
            ramwen_q   <= bus.dWEN;
            state_q    <= DACC;
          end else if (bus.iREN) begin
            last_q    <= GRANT_I;
            ramaddr_q <= bus.iaddr;
            wr_q      <= 1'b0;
            ramren_q  <= 1'b1;
            ramwen_q  <= 1'b0;
            state_q   <= IACC;
          end
        end
        IACC, DACC: begin
          if (done_now) begin
            ramren_q <= 1'b0;
            ramwen_q <= 1'b0;
            state_q  <= DONE;
            if (err_now) memerr_q <= 1'b1;
            if (state_q == IACC) begin
              ihit_q  <= 1'b1;
              iload_q <= rd_word;
            end else begin
              dhit_q <= 1'b1;
              if (!wr_q) dload_q <= rd_word;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.ramREN   = ramren_q;
  assign bus.ramWEN   = ramwen_q;
  assign bus.ramaddr  = ramaddr_q;
  assign bus.ramstore = ramstore_q;
  assign bus.iload    = iload_q;
  assign bus.dload    = dload_q;
  assign bus.ihit     = ihit_q;
  assign bus.dhit     = dhit_q;
  assign bus.memerr   = memerr_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter against a transaction-level model of grant,
// latency, load and error behaviour.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int TO = 5;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO), .CNT_W(8)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  bit          m_last_d;
  logic [31:0] m_iload, m_dload;
  bit          m_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_last_d = 1'b0;
    m_iload  = '0;
    m_dload  = '0;
    m_err    = 1'b0;
  endtask

  // One complete transaction from the IDLE cycle through the cycle after the hit.
  // L = BUSY cycles before the RAM answers; rerr makes the answer ERROR instead of ACCESS.
  task automatic run_txn(input bit ir, input bit dr, input bit dw, input int L, input bit rerr,
                         input logic [31:0] ia, input logic [31:0] da,
                         input logic [31:0] ds, input logic [31:0] rl);
    bit          want_d, is_wr, finished, got_err;
    logic [31:0] exp_addr, word;
    int          c;
    bus.iREN = ir; bus.dREN = dr; bus.dWEN = dw;
    bus.iaddr = ia; bus.daddr = da; bus.dstore = ds;
    bus.ramstate = FREE;
    want_d   = (dr || dw) && (!ir || !m_last_d);
    is_wr    = want_d && dw;
    exp_addr = want_d ? da : ia;
    @(posedge CLK);
    @(negedge CLK);
    bus.iREN = 1'b0; bus.dREN = 1'b0; bus.dWEN = 1'b0;
    bus.iaddr = $urandom; bus.daddr = $urandom; bus.dstore = $urandom;
    c = 0; finished = 0; got_err = 0;
    while (!finished) begin
      chk("ramREN", 32'(bus.ramREN), 32'(!is_wr));
      chk("ramWEN", 32'(bus.ramWEN), 32'(is_wr));
      chk("ramaddr", bus.ramaddr, exp_addr);
      if (is_wr) chk("ramstore", bus.ramstore, ds);
      chk("hit_during_acc", 32'({bus.ihit, bus.dhit}), 32'(0));
      bus.ramload = rl;
      if (c < L) bus.ramstate = BUSY;
      else       bus.ramstate = rerr ? ERROR : ACCESS;
      if (c >= L && !rerr) finished = 1;
      else if (c >= L || c == TO) begin finished = 1; got_err = 1; end
      @(negedge CLK);
      c++;
    end
    bus.ramstate = FREE;
    bus.ramload  = $urandom;
    word = got_err ? 32'hBAD1BAD1 : rl;
    if (got_err) m_err = 1'b1;
    if (want_d) begin
      if (!is_wr) m_dload = word;
    end else begin
      m_iload = word;
    end
    m_last_d = want_d;
    chk("ihit", 32'(bus.ihit), 32'(!want_d));
    chk("dhit", 32'(bus.dhit), 32'(want_d));
    chk("iload", bus.iload, m_iload);
    chk("dload", bus.dload, m_dload);
    chk("memerr", 32'(bus.memerr), 32'(m_err));
    chk("strobes_done", 32'({bus.ramREN, bus.ramWEN}), 32'(0));
    @(negedge CLK);
    chk("hit_after", 32'({bus.ihit, bus.dhit}), 32'(0));
  endtask

  initial begin
    bit ir, dr, dw;
    int kind;
    RST = 1'b1;
    bus.iREN = 0; bus.dREN = 0; bus.dWEN = 0;
    bus.iaddr = '0; bus.daddr = '0; bus.dstore = '0;
    bus.ramload = '0; bus.ramstate = FREE;
    model_reset();
    repeat (2) @(negedge CLK);
    chk("rst_iload", bus.iload, 32'h0);
    chk("rst_dload", bus.dload, 32'h0);
    chk("rst_hits", 32'({bus.ihit, bus.dhit}), 32'(0));
    chk("rst_strobes", 32'({bus.ramREN, bus.ramWEN}), 32'(0));
    chk("rst_ramaddr", bus.ramaddr, 32'h0);
    chk("rst_memerr", 32'(bus.memerr), 32'(0));
    RST = 1'b0;
    @(negedge CLK);

    run_txn(1, 0, 0, 2, 0, 32'h100, 32'h0, 32'h0, 32'h8C220004);
    // Tie handling: alternation starting from the side opposite the last grant.
    run_txn(1, 1, 0, 1, 0, 32'h300, 32'h400, 32'h0, 32'h11111111);
    run_txn(1, 1, 0, 0, 0, 32'h304, 32'h404, 32'h0, 32'h22222222);
    run_txn(1, 1, 0, 3, 0, 32'h308, 32'h408, 32'h0, 32'h33333333);
    run_txn(1, 1, 0, 0, 0, 32'h30C, 32'h40C, 32'h0, 32'h44444444);
    run_txn(0, 0, 1, 0, 0, 32'h0, 32'h200, 32'hDEADBEEF, 32'h55555555);
    run_txn(0, 1, 1, 1, 0, 32'h0, 32'h204, 32'hCAFEF00D, 32'h66666666);

    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(0, 2);
      ir = (kind != 1);
      dr = (kind != 0) && ($urandom_range(0, 1) == 1);
      dw = (kind != 0) && !dr ? 1'b1 : (kind != 0) && ($urandom_range(0, 3) == 0);
      run_txn(ir, dr, dw,
              ($urandom_range(0, 9) == 0) ? 9 : $urandom_range(0, 3),
              ($urandom_range(0, 9) == 0),
              $urandom, $urandom, $urandom, $urandom);
    end

    // Reset to clear memerr, then a stuck RAM on a D read must time out.
    RST = 1'b1; #1; RST = 1'b0;
    model_reset();
    @(negedge CLK);
    chk("rst2_memerr", 32'(bus.memerr), 32'(0));
    run_txn(0, 1, 0, 100, 0, 32'h0, 32'h500, 32'h0, 32'h77777777);
    chk("timeout_dload", bus.dload, 32'hBAD1BAD1);
    run_txn(1, 0, 0, 0, 0, 32'h600, 32'h0, 32'h0, 32'h88888888);
    chk("memerr_sticky", 32'(bus.memerr), 32'(1));

    // Reset during a BUSY access: strobes drop at once and no hit follows.
    bus.dREN = 1'b1; bus.daddr = 32'h700;
    @(posedge CLK);
    @(negedge CLK);
    bus.dREN = 1'b0;
    bus.ramstate = BUSY;
    chk("pre_rst_ramREN", 32'(bus.ramREN), 32'(1));
    #2 RST = 1'b1;
    #1;
    chk("rst_mid_ramREN", 32'(bus.ramREN), 32'(0));
    chk("rst_mid_ramWEN", 32'(bus.ramWEN), 32'(0));
    chk("rst_mid_memerr", 32'(bus.memerr), 32'(0));
    @(negedge CLK);
    RST = 1'b0;
    bus.ramstate = FREE;
    model_reset();
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      chk("rst_mid_nohit", 32'({bus.ihit, bus.dhit, bus.ramREN, bus.ramWEN}), 32'(0));
    end
    run_txn(1, 1, 0, 1, 0, 32'h800, 32'h900, 32'h0, 32'h99999999);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "simulation time limit");
  end
endmodule
